// File: rtl/i2c_responder_pkg.sv
// Shared definitions for the I2C register-access target: FSM states, bus constants and
// the default target address.
package i2c_responder_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_WAIT_STOP
  } state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h42;

  localparam logic [3:0] BYTE_BITS = 4'd8;

endpackage

// File: rtl/i2c_line_sync.sv
// Bus input conditioning: synchronizes SCL/SDA into CLK and flags SCL edges and
// START/STOP conditions from the synchronized levels.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic reset_in,
  input  logic scl_read,
  input  logic sda_read,
  output logic sda_level,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_level;
  logic                   scl_prev;
  logic                   sda_prev;

  // Idle bus is high, so everything resets to 1 to avoid false edges after reset.
  always_ff @(posedge CLK or posedge reset_in) begin
    if (reset_in) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_read};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_read};
      scl_prev <= scl_level;
      sda_prev <= sda_level;
    end
  end

  assign scl_level = scl_sync[SYNC_STAGES-1];
  assign sda_level = sda_sync[SYNC_STAGES-1];

  assign scl_rise  = scl_level & ~scl_prev;
  assign scl_fall  = ~scl_level & scl_prev;

  // SDA may only move while SCL is high (both samples) for a START/STOP.
  assign start_det = scl_level & scl_prev & sda_prev & ~sda_level;
  assign stop_det  = scl_level & scl_prev & ~sda_prev & sda_level;

endmodule

// File: rtl/i2c_responder.sv
// I2C target giving a controller byte access to a register file through a pointer
// with auto-increment; no clock stretching, read data expected 1 CLK after rd_strobe.
//   IDLE      bus free          | ADDR       shifting address + R/W
//   ADDR_ACK  ACK own address   | PTR        shifting register pointer
//   PTR_ACK   ACK pointer       | WDATA      shifting write byte
//   WDATA_ACK ACK write byte    | RDATA      driving read byte
//   RDATA_ACK controller ACK    | WAIT_STOP  ignored until STOP/START
module i2c_responder
  import i2c_responder_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = DEFAULT_DEV_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       reset_in,
  input  logic       scl_read,
  input  logic       sda_read,
  output logic       sda_write,
  output logic [7:0] reg_addr,
  output logic [7:0] wr_data,
  output logic       wr_strobe,
  output logic       rd_strobe,
  input  logic [7:0] rd_data,
  output logic       busy
);

  logic   sda_level;
  logic   scl_rise;
  logic   scl_fall;
  logic   start_det;
  logic   stop_det;

  state_t     state;
  state_t     state_next;
  logic [3:0] bit_cnt;
  logic [7:0] shreg;
  logic       rw_q;
  logic       ack_q;
  logic       load_pend;

  logic       byte_done;
  logic       addr_match;
  logic       rx_state;
  logic       sda_next;
  logic       wr_fire;
  logic       rd_fire;
  logic       ptr_load;
  logic       addr_inc;

  i2c_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_line_sync (
    .CLK      (CLK),
    .reset_in (reset_in),
    .scl_read (scl_read),
    .sda_read (sda_read),
    .sda_level(sda_level),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det)
  );

  assign byte_done  = (bit_cnt == BYTE_BITS);
  assign addr_match = (shreg[7:1] == DEV_ADDR);
  assign rx_state   = (state == ST_ADDR) || (state == ST_PTR) || (state == ST_WDATA);

  always_ff @(posedge CLK or posedge reset_in) begin
    if (reset_in) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // START/STOP override every state; byte and ACK slots end on SCL falling edges.
  always_comb begin
    state_next = state;
    if (stop_det) begin
      state_next = ST_IDLE;
    end else if (start_det) begin
      state_next = ST_ADDR;
    end else begin
      case (state)
        ST_ADDR:      if (scl_fall && byte_done) state_next = addr_match ? ST_ADDR_ACK : ST_WAIT_STOP;
        ST_ADDR_ACK:  if (scl_fall) state_next = rw_q ? ST_RDATA : ST_PTR;
        ST_PTR:       if (scl_fall && byte_done) state_next = ST_PTR_ACK;
        ST_PTR_ACK:   if (scl_fall) state_next = ST_WDATA;
        ST_WDATA:     if (scl_fall && byte_done) state_next = ST_WDATA_ACK;
        ST_WDATA_ACK: if (scl_fall) state_next = ST_WDATA;
        ST_RDATA:     if (scl_fall && byte_done) state_next = ST_RDATA_ACK;
        ST_RDATA_ACK: if (scl_fall) state_next = (ack_q == I2C_ACK) ? ST_RDATA : ST_WAIT_STOP;
        default:      state_next = state;
      endcase
    end
  end

  always_comb begin
    sda_next = 1'b1;
    case (state)
      ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: sda_next = I2C_ACK;
      ST_RDATA:                              sda_next = shreg[7];
      default:                               sda_next = 1'b1;
    endcase
    wr_fire  = scl_rise && (state == ST_WDATA) && (bit_cnt == BYTE_BITS - 4'd1);
    ptr_load = scl_fall && (state == ST_PTR) && byte_done;
    rd_fire  = scl_fall && (((state == ST_ADDR_ACK) && rw_q) ||
                            ((state == ST_RDATA_ACK) && (ack_q == I2C_ACK)));
    addr_inc = scl_fall && ((state == ST_WDATA_ACK) ||
                            ((state == ST_RDATA_ACK) && (ack_q == I2C_ACK)));
  end

  // sda_write is registered from the state, so it moves one CLK after the state
  // changes on a detected SCL fall; reset releases it immediately.
  always_ff @(posedge CLK or posedge reset_in) begin
    if (reset_in) begin
      sda_write <= 1'b1;
      bit_cnt   <= 4'd0;
      shreg     <= 8'h00;
      rw_q      <= 1'b0;
      ack_q     <= I2C_NACK;
      load_pend <= 1'b0;
      reg_addr  <= 8'h00;
      wr_data   <= 8'h00;
      wr_strobe <= 1'b0;
      rd_strobe <= 1'b0;
      busy      <= 1'b0;
    end else begin
      sda_write <= sda_next;
      wr_strobe <= wr_fire;
      rd_strobe <= rd_fire;
      load_pend <= rd_strobe;

      if (start_det || stop_det || (scl_fall && byte_done)) begin
        bit_cnt <= 4'd0;
      end else if (scl_rise && (rx_state || (state == ST_RDATA)) && !byte_done) begin
        bit_cnt <= bit_cnt + 4'd1;
      end

      // Read bytes are preset to all ones so SDA stays released until rd_data lands.
      if (rd_fire) begin
        shreg <= 8'hFF;
      end else if (load_pend) begin
        shreg <= rd_data;
      end else if ((state == ST_RDATA) && scl_fall && !byte_done) begin
        shreg <= {shreg[6:0], 1'b1};
      end else if (scl_rise && rx_state && !byte_done) begin
        shreg <= {shreg[6:0], sda_level};
      end

      if ((state == ST_ADDR) && scl_fall && byte_done) begin
        rw_q <= shreg[0];
      end

      if ((state == ST_RDATA_ACK) && scl_rise) begin
        ack_q <= sda_level;
      end

      if (wr_fire) begin
        wr_data <= {shreg[6:0], sda_level};
      end

      if (ptr_load) begin
        reg_addr <= shreg;
      end else if (addr_inc) begin
        reg_addr <= reg_addr + 8'd1;
      end

      if ((state_next == ST_IDLE) || (state_next == ST_WAIT_STOP)) begin
        busy <= 1'b0;
      end else if ((state == ST_ADDR) && (state_next == ST_ADDR_ACK)) begin
        busy <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2c_responder.sv
// Bench: bus-level controller tasks plus a register-file model; strobes and bus
// activity are checked against transaction-level expectations.
module tb_i2c_responder;

  localparam int Q = 8;

  logic       CLK      = 1'b0;
  logic       reset_in = 1'b1;
  logic       scl_ctrl = 1'b1;
  logic       sda_ctrl = 1'b1;
  logic       sda_bus;
  logic       sda_write;
  logic       wr_strobe;
  logic       rd_strobe;
  logic       busy;
  logic [7:0] reg_addr;
  logic [7:0] wr_data;
  logic [7:0] rd_data = 8'h00;

  int tests = 0;
  int fails = 0;
  logic quiet = 1'b0;

  logic [7:0]  ram [256];
  bit          ram_v [256];
  logic [7:0]  model_mem [256];
  logic [7:0]  model_ptr = 8'h00;
  logic [15:0] exp_wr_q [$];
  logic [7:0]  exp_rd_q [$];
  logic [7:0]  tx_buf [4];
  logic [7:0]  rx_buf [4];
  logic [15:0] mon_wr;
  logic [7:0]  mon_rd;

  assign sda_bus = sda_ctrl & sda_write;

  always #5 CLK = ~CLK;

  i2c_responder #(
    .DEV_ADDR   (7'h42),
    .SYNC_STAGES(2)
  ) dut (
    .CLK      (CLK),
    .reset_in (reset_in),
    .scl_read (scl_ctrl),
    .sda_read (sda_bus),
    .sda_write(sda_write),
    .reg_addr (reg_addr),
    .wr_data  (wr_data),
    .wr_strobe(wr_strobe),
    .rd_strobe(rd_strobe),
    .rd_data  (rd_data),
    .busy     (busy)
  );

  function automatic logic [7:0] fill_byte(input logic [7:0] a);
    return (a * 8'd7) ^ 8'hA5;
  endfunction

  // Register file behind the target: registered read, one CLK after rd_strobe.
  always @(posedge CLK) begin
    if (wr_strobe) begin
      ram[reg_addr]   <= wr_data;
      ram_v[reg_addr] <= 1'b1;
    end
    if (rd_strobe) rd_data <= ram_v[reg_addr] ? ram[reg_addr] : fill_byte(reg_addr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (!reset_in) begin
      if (wr_strobe) begin
        if (exp_wr_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL wr_strobe_unexpected: addr %0h data %0h, none expected", reg_addr, wr_data);
        end else begin
          mon_wr = exp_wr_q.pop_front();
          check("wr_strobe_addr_data", {16'h0, reg_addr, wr_data}, {16'h0, mon_wr});
        end
      end
      if (rd_strobe) begin
        if (exp_rd_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL rd_strobe_unexpected: addr %0h, none expected", reg_addr);
        end else begin
          mon_rd = exp_rd_q.pop_front();
          check("rd_strobe_addr", reg_addr, mon_rd);
        end
      end
      if (quiet) begin
        check("quiet_sda_write", sda_write, 1);
        check("quiet_busy", busy, 0);
      end
    end
  end

  task automatic wq(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic i2c_start();
    sda_ctrl = 1'b1; wq(Q);
    scl_ctrl = 1'b1; wq(Q);
    sda_ctrl = 1'b0; wq(Q);
    scl_ctrl = 1'b0; wq(Q);
  endtask

  task automatic i2c_stop();
    sda_ctrl = 1'b0; wq(Q);
    scl_ctrl = 1'b1; wq(Q);
    sda_ctrl = 1'b1; wq(2 * Q);
  endtask

  task automatic write_bit(input logic b);
    sda_ctrl = b;    wq(Q);
    scl_ctrl = 1'b1; wq(2 * Q);
    scl_ctrl = 1'b0; wq(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_ctrl = 1'b1; wq(Q);
    scl_ctrl = 1'b1; wq(Q);
    b = sda_bus;     wq(Q);
    scl_ctrl = 1'b0; wq(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(ack);
  endtask

  task automatic tx_write(input logic [7:0] ptr, input int n);
    logic ack;
    logic [7:0] a;
    i2c_start();
    write_byte(8'h84, ack);
    check("wr_addr_ack", ack, 0);
    check("wr_busy", busy, 1);
    write_byte(ptr, ack);
    check("wr_ptr_ack", ack, 0);
    for (int i = 0; i < n; i++) begin
      a = ptr + 8'(i);
      exp_wr_q.push_back({a, tx_buf[i]});
      model_mem[a] = tx_buf[i];
      write_byte(tx_buf[i], ack);
      check("wr_data_ack", ack, 0);
    end
    model_ptr = ptr + 8'(n);
    i2c_stop();
    check("wr_idle_busy", busy, 0);
    check("wr_idle_sda", sda_write, 1);
  endtask

  task automatic tx_read(input logic [7:0] ptr, input bit set_ptr, input int n);
    logic ack;
    logic [7:0] a;
    logic [7:0] d;
    if (set_ptr) begin
      i2c_start();
      write_byte(8'h84, ack);
      check("rdptr_addr_ack", ack, 0);
      write_byte(ptr, ack);
      check("rdptr_ptr_ack", ack, 0);
      model_ptr = ptr;
    end
    for (int i = 0; i < n; i++) exp_rd_q.push_back(model_ptr + 8'(i));
    i2c_start();
    write_byte(8'h85, ack);
    check("rd_addr_ack", ack, 0);
    check("rd_busy", busy, 1);
    for (int i = 0; i < n; i++) begin
      a = model_ptr + 8'(i);
      read_byte(d, (i == n - 1));
      check("rd_byte", d, model_mem[a]);
      rx_buf[i] = d;
    end
    model_ptr = model_ptr + 8'(n - 1);
    check("rd_release_after_nack", sda_write, 1);
    i2c_stop();
    check("rd_idle_busy", busy, 0);
  endtask

  task automatic tx_wrong(input logic [6:0] addr, input logic rw);
    logic ack;
    quiet = 1'b1;
    i2c_start();
    write_byte({addr, rw}, ack);
    check("wrong_addr_nack", ack, 1);
    write_byte(8'h00, ack);
    check("wrong_data_nack", ack, 1);
    i2c_stop();
    quiet = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ack;
    logic [6:0] wa;
    int kind;
    int n;

    for (int i = 0; i < 256; i++) model_mem[i] = fill_byte(8'(i));

    wq(3);
    check("rst_sda_write", sda_write, 1);
    check("rst_reg_addr", reg_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_wr_strobe", wr_strobe, 0);
    check("rst_rd_strobe", rd_strobe, 0);
    check("rst_busy", busy, 0);
    reset_in = 1'b0;
    wq(Q);

    // Basic write: two bytes from pointer 0x10.
    tx_buf[0] = 8'hA5; tx_buf[1] = 8'h5A;
    tx_write(8'h10, 2);
    check("write_ptr_after", reg_addr, 8'h12);
    check("write_last_data", wr_data, 8'h5A);

    // Read back through a pointer write and repeated START.
    tx_buf[0] = 8'h3C; tx_buf[1] = 8'hC3;
    tx_write(8'h20, 2);
    tx_read(8'h20, 1'b1, 2);
    check("read_byte0_literal", rx_buf[0], 8'h3C);
    check("read_byte1_literal", rx_buf[1], 8'hC3);
    check("read_ptr_after_nack", reg_addr, 8'h21);

    // Pointer wrap.
    tx_buf[0] = 8'h11; tx_buf[1] = 8'h22;
    tx_write(8'hFF, 2);
    check("wrap_ptr_after", reg_addr, 8'h01);

    tx_wrong(7'h43, 1'b0);

    // STOP after 4 data bits discards the partial byte.
    i2c_start();
    write_byte(8'h84, ack);
    check("partial_addr_ack", ack, 0);
    write_byte(8'h50, ack);
    check("partial_ptr_ack", ack, 0);
    model_ptr = 8'h50;
    for (int i = 0; i < 4; i++) write_bit(1'(i & 1));
    i2c_stop();
    check("partial_busy", busy, 0);
    check("partial_sda", sda_write, 1);
    check("partial_ptr", reg_addr, 8'h50);

    for (int it = 0; it < 12; it++) begin
      kind = $urandom_range(0, 3);
      n = $urandom_range(1, 3);
      case (kind)
        0: begin
          for (int i = 0; i < n; i++) tx_buf[i] = 8'($urandom);
          tx_write(8'($urandom), n);
        end
        1: tx_read(8'($urandom), 1'b1, n);
        2: begin
          wa = 7'($urandom_range(0, 127));
          while (wa == 7'h42) wa = 7'($urandom_range(0, 127));
          tx_wrong(wa, 1'($urandom_range(0, 1)));
        end
        default: tx_read(model_ptr, 1'b0, n);
      endcase
    end

    // Reset while the target is driving a 0 data bit.
    tx_buf[0] = 8'h00;
    tx_write(8'h30, 1);
    i2c_start();
    write_byte(8'h84, ack);
    check("rst_case_addr_ack", ack, 0);
    write_byte(8'h30, ack);
    check("rst_case_ptr_ack", ack, 0);
    exp_rd_q.push_back(8'h30);
    i2c_start();
    write_byte(8'h85, ack);
    check("rst_case_rd_ack", ack, 0);
    sda_ctrl = 1'b1; wq(Q);
    scl_ctrl = 1'b1; wq(Q);
    check("rst_case_bit_driven_low", sda_write, 0);
    #2 reset_in = 1'b1;
    #1 check("rst_case_async_release", sda_write, 1);
    wq(3);
    reset_in = 1'b0;
    model_ptr = 8'h00;
    wq(Q);
    check("rst_case_reg_addr", reg_addr, 0);
    check("rst_case_busy", busy, 0);
    i2c_start();
    write_byte(8'h84, ack);
    check("post_reset_addr_ack", ack, 0);
    i2c_stop();
    check("post_reset_busy", busy, 0);

    wq(Q);
    check("wr_queue_drained", exp_wr_q.size(), 0);
    check("rd_queue_drained", exp_rd_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
